// File: rtl/renkon_post.sv
`default_nettype none
// ============================================================================
// Module   : renkon_post
// Brief    : Bias add, saturation, activation and non-overlapping max pooling
//            of the accumulated convolution stream, with start/abort framing.
// Revision : 1.0
// ============================================================================
module renkon_post #(
    parameter int DWIDTH     = 16,
    parameter int AWIDTH     = 32,
    parameter int FRAC       = 8,
    parameter int LWIDTH     = 10,
    parameter int MAXFEA     = 256,
    parameter int PMAX       = 4,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LWIDTH-1:0]        fea_size,
    input  logic [LWIDTH-1:0]        pool_size,
    input  logic [1:0]               act_mode,
    input  logic signed [DWIDTH-1:0] bias,
    input  logic                     in_valid,
    input  logic signed [AWIDTH-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DWIDTH-1:0] out_data,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = (MAXFEA > 1) ? $clog2(MAXFEA) : 1;
    localparam int WW = $clog2(PMAX + 1);
    localparam int SW = AWIDTH + 1;
    localparam logic [LWIDTH-1:0] L_ONE = 1;
    localparam logic [WW-1:0]     W_ONE = 1;
    localparam logic [AW-1:0]     P_ONE = 1;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    logic signed [DWIDTH-1:0] row_buf [MAXFEA];

    logic                     busy_q, busy_d, all_in_q, all_in_d;
    logic [LWIDTH-1:0]        fea_q, fea_d, pool_q, pool_d;
    logic [1:0]               act_q, act_d;
    logic signed [DWIDTH-1:0] bias_q, bias_d;
    logic [LWIDTH-1:0]        col_q, col_d, row_q, row_d;
    logic [WW-1:0]            wcol_q, wcol_d, wrow_q, wrow_d;
    logic [AW-1:0]            pcol_q, pcol_d;
    logic                     s1_vld_q, s1_vld_d, s1_keep_q, s1_keep_d;
    logic                     s1_first_q, s1_first_d, s1_emit_q, s1_emit_d, s1_last_q, s1_last_d;
    logic signed [DWIDTH-1:0] s1_sat_q, s1_sat_d;
    logic [AW-1:0]            s1_pcol_q, s1_pcol_d;
    logic                     s2_vld_q, s2_vld_d, s2_keep_q, s2_keep_d;
    logic                     s2_first_q, s2_first_d, s2_emit_q, s2_emit_d, s2_last_q, s2_last_d;
    logic signed [DWIDTH-1:0] s2_act_q, s2_act_d, s2_rd_q, s2_rd_d;
    logic [AW-1:0]            s2_pcol_q, s2_pcol_d;
    logic                     out_valid_q, out_valid_d, done_q, done_d;
    logic signed [DWIDTH-1:0] out_data_q, out_data_d;

    logic                     accept, col_end, row_end, wcol_end, wrow_end, keep, wr_en;
    logic [LWIDTH:0]          win_c, win_r;
    logic signed [AWIDTH-1:0] in_shift;
    logic signed [SW-1:0]     sum;
    logic signed [DWIDTH-1:0] sat, act, pooled;

    always_comb begin
        busy_d = busy_q;   all_in_d = all_in_q;
        fea_d = fea_q;     pool_d = pool_q;   act_d = act_q;   bias_d = bias_q;
        col_d = col_q;     row_d = row_q;     wcol_d = wcol_q; wrow_d = wrow_q; pcol_d = pcol_q;

        accept   = busy_q && in_valid && !all_in_q && !start;
        col_end  = (col_q == fea_q - L_ONE);
        row_end  = (row_q == fea_q - L_ONE);
        wcol_end = ({{(LWIDTH-WW){1'b0}}, wcol_q} == pool_q - L_ONE);
        wrow_end = ({{(LWIDTH-WW){1'b0}}, wrow_q} == pool_q - L_ONE);
        // Window origin plus pool size past the map edge means a trailing partial window.
        win_c = {1'b0, col_q} - {{(LWIDTH-WW+1){1'b0}}, wcol_q} + {1'b0, pool_q};
        win_r = {1'b0, row_q} - {{(LWIDTH-WW+1){1'b0}}, wrow_q} + {1'b0, pool_q};
        keep  = (win_c <= {1'b0, fea_q}) && (win_r <= {1'b0, fea_q});

        in_shift = in_data >>> FRAC;
        sum      = SW'(in_shift) + SW'(bias_q);
        if (sum > SAT_MAX)
            sat = SAT_MAX[DWIDTH-1:0];
        else if (sum < SAT_MIN)
            sat = SAT_MIN[DWIDTH-1:0];
        else
            sat = sum[DWIDTH-1:0];

        case (act_q)
            2'd1:    act = s1_sat_q[DWIDTH-1] ? '0 : s1_sat_q;
            2'd2:    act = s1_sat_q[DWIDTH-1] ? (s1_sat_q >>> LEAK_SHIFT) : s1_sat_q;
            default: act = s1_sat_q;
        endcase

        pooled = (s2_first_q || (s2_act_q > s2_rd_q)) ? s2_act_q : s2_rd_q;
        wr_en  = s2_vld_q && s2_keep_q && (pool_q != L_ONE);

        s1_vld_d   = accept;
        s1_sat_d   = sat;
        s1_keep_d  = keep;
        s1_first_d = (wcol_q == '0) && (wrow_q == '0);
        s1_emit_d  = wcol_end && wrow_end;
        s1_last_d  = col_end && row_end;
        s1_pcol_d  = pcol_q;

        s2_vld_d   = s1_vld_q;
        s2_keep_d  = s1_keep_q;
        s2_first_d = s1_first_q;
        s2_emit_d  = s1_emit_q;
        s2_last_d  = s1_last_q;
        s2_pcol_d  = s1_pcol_q;
        s2_act_d   = act;
        // The entry being written this edge is not yet in the array; forward it.
        s2_rd_d    = (wr_en && (s2_pcol_q == s1_pcol_q)) ? pooled : row_buf[s1_pcol_q];

        out_valid_d = s2_vld_q && s2_keep_q && s2_emit_q;
        out_data_d  = out_valid_d ? pooled : out_data_q;
        done_d      = s2_vld_q && s2_last_q;

        if (done_q)
            busy_d = 1'b0;

        if (accept) begin
            if (col_end) begin
                col_d  = '0;
                row_d  = row_q + L_ONE;
                wcol_d = '0;
                pcol_d = '0;
                wrow_d = wrow_end ? '0 : wrow_q + W_ONE;
            end else begin
                col_d = col_q + L_ONE;
                if (wcol_end) begin
                    wcol_d = '0;
                    pcol_d = pcol_q + P_ONE;
                end else begin
                    wcol_d = wcol_q + W_ONE;
                end
            end
            if (col_end && row_end)
                all_in_d = 1'b1;
        end

        if (start) begin
            busy_d   = 1'b1;
            all_in_d = 1'b0;
            fea_d    = fea_size;
            pool_d   = pool_size;
            act_d    = act_mode;
            bias_d   = bias;
            col_d    = '0;
            row_d    = '0;
            wcol_d   = '0;
            wrow_d   = '0;
            pcol_d   = '0;
            s2_vld_d    = 1'b0;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;  all_in_q <= 1'b0;
            fea_q  <= '0;    pool_q   <= '0;   act_q  <= '0;  bias_q <= '0;
            col_q  <= '0;    row_q    <= '0;   wcol_q <= '0;  wrow_q <= '0;  pcol_q <= '0;
            s1_vld_q <= 1'b0; s1_keep_q <= 1'b0; s1_first_q <= 1'b0; s1_emit_q <= 1'b0;
            s1_last_q <= 1'b0; s1_sat_q <= '0; s1_pcol_q <= '0;
            s2_vld_q <= 1'b0; s2_keep_q <= 1'b0; s2_first_q <= 1'b0; s2_emit_q <= 1'b0;
            s2_last_q <= 1'b0; s2_act_q <= '0; s2_rd_q <= '0; s2_pcol_q <= '0;
            out_valid_q <= 1'b0; out_data_q <= '0; done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;  all_in_q <= all_in_d;
            fea_q  <= fea_d;   pool_q   <= pool_d;  act_q  <= act_d;  bias_q <= bias_d;
            col_q  <= col_d;   row_q    <= row_d;   wcol_q <= wcol_d; wrow_q <= wrow_d; pcol_q <= pcol_d;
            s1_vld_q <= s1_vld_d; s1_keep_q <= s1_keep_d; s1_first_q <= s1_first_d;
            s1_emit_q <= s1_emit_d; s1_last_q <= s1_last_d; s1_sat_q <= s1_sat_d;
            s1_pcol_q <= s1_pcol_d;
            s2_vld_q <= s2_vld_d; s2_keep_q <= s2_keep_d; s2_first_q <= s2_first_d;
            s2_emit_q <= s2_emit_d; s2_last_q <= s2_last_d; s2_act_q <= s2_act_d;
            s2_rd_q <= s2_rd_d; s2_pcol_q <= s2_pcol_d;
            out_valid_q <= out_valid_d; out_data_q <= out_data_d; done_q <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            row_buf[s2_pcol_q] <= pooled;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_renkon_post.sv
`default_nettype none
// ============================================================================
// Module   : tb_renkon_post
// Brief    : Directed self-checking bench for renkon_post.
// Revision : 1.0
// ============================================================================
module tb_renkon_post;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [9:0]         fea_size = '0;
    logic [9:0]         pool_size = '0;
    logic [1:0]         act_mode = '0;
    logic signed [15:0] bias = '0;
    logic               in_valid = 1'b0;
    logic signed [31:0] in_data = '0;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    renkon_post #(
        .DWIDTH(16), .AWIDTH(32), .FRAC(8), .LWIDTH(10),
        .MAXFEA(256), .PMAX(4), .LEAK_SHIFT(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .fea_size(fea_size),
        .pool_size(pool_size), .act_mode(act_mode), .bias(bias),
        .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
        .out_data(out_data), .busy(busy), .done(done)
    );

    int                 checks = 0;
    int                 fails  = 0;
    int                 cyc    = 0;
    logic signed [15:0] outq[$];
    int                 outc[$];
    int                 done_cnt = 0;
    int                 done_cyc = 0;
    logic               busy_at_done, busy_after_done, prev_done;
    logic signed [31:0] pix[$];
    int                 exp_v[$];
    int                 acc_cyc[64];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_done) busy_after_done = busy;
        prev_done = done;
        if (out_valid) begin
            outq.push_back(out_data);
            outc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
    endtask

    task automatic do_start(input int fea, input int pool, input int act, input int b);
        outq.delete();
        outc.delete();
        done_cnt        = 0;
        prev_done       = 1'b0;
        busy_at_done    = 1'bx;
        busy_after_done = 1'bx;
        in_valid  = 1'b0;
        start     = 1'b1;
        fea_size  = 10'(fea);
        pool_size = 10'(pool);
        act_mode  = 2'(act);
        bias      = 16'(b);
        tick();
        start = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    task automatic feed(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    in_data  = $urandom;
                    tick();
                end
            end
            in_valid   = 1'b1;
            in_data    = pix[i];
            acc_cyc[i] = cyc;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic run(input bit gaps, input bit extra);
        feed(pix.size(), gaps);
        in_valid = extra;
        in_data  = 32'sh12345678;
        for (int k = 0; k < 20 && done_cnt == 0; k++) tick();
        for (int k = 0; k < 4; k++) tick();
        in_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int fea, input int pool);
        int pw;
        int np;
        pw = fea / pool;
        np = fea * fea;
        chk({tag, "_cnt"}, outq.size(), exp_v.size());
        for (int j = 0; j < exp_v.size() && j < outq.size(); j++) begin
            int idx;
            idx = ((j / pw) * pool + pool - 1) * fea + (j % pw) * pool + pool - 1;
            chk($sformatf("%s_val%0d", tag, j), outq[j], exp_v[j]);
            chk($sformatf("%s_cyc%0d", tag, j), outc[j], acc_cyc[idx] + 3);
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_cyc"}, done_cyc, acc_cyc[np-1] + 3);
        chk({tag, "_busy_at_done"}, busy_at_done, 1);
        chk({tag, "_busy_after"}, busy_after_done, 0);
    endtask

    task automatic set_bypass16();
        pix.delete();
        for (int k = 0; k < 16; k++) pix.push_back(k * 65536);
    endtask

    task automatic set_ramp16();
        pix.delete();
        for (int k = 0; k < 16; k++) pix.push_back((k - 8) * 65536);
    endtask

    task automatic set_alt25();
        pix.delete();
        for (int k = 0; k < 25; k++) pix.push_back(((k % 2) == 0 ? k : -k) * 65536);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        prev_done = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Pixels offered while idle must not move the counters.
        in_valid = 1'b1;
        in_data  = 5 * 65536;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("idle_out", outq.size(), 0);
        chk("idle_busy", busy, 0);

        do_start(4, 1, 0, 0);
        set_bypass16();
        exp_v.delete();
        for (int k = 0; k < 16; k++) exp_v.push_back(k * 256);
        run(1'b0, 1'b1);
        check_frame("bypass", 4, 1);

        do_start(4, 2, 1, 0);
        set_ramp16();
        exp_v = '{0, 0, 1280, 1792};
        run(1'b0, 1'b0);
        check_frame("relu_pool", 4, 2);

        do_start(2, 1, 0, 256);
        pix = '{32'sh7FFFFFFF, 32'sh80000000, -3 * 65536, 32'sh00000080};
        exp_v = '{32767, -32768, -512, 256};
        run(1'b0, 1'b0);
        check_frame("sat_bias", 2, 1);

        do_start(2, 1, 1, 0);
        pix = '{32'sh80000000, -64 * 256, 5 * 65536, 0};
        exp_v = '{0, 0, 1280, 0};
        run(1'b0, 1'b0);
        check_frame("relu", 2, 1);

        do_start(2, 1, 2, 0);
        pix = '{-64 * 256, -256, 32'sh80000000, 100 * 256};
        exp_v = '{-8, -1, -4096, 100};
        run(1'b0, 1'b0);
        check_frame("leaky", 2, 1);

        do_start(1, 1, 3, -256);
        pix = '{-5 * 256};
        exp_v = '{-261};
        run(1'b0, 1'b0);
        check_frame("act3", 1, 1);

        do_start(5, 2, 0, 0);
        set_alt25();
        exp_v = '{1536, 2048, 4096, 4608};
        run(1'b0, 1'b0);
        check_frame("partial", 5, 2);

        do_start(5, 2, 0, 0);
        set_alt25();
        run(1'b1, 1'b0);
        check_frame("partial_gap", 5, 2);

        do_start(4, 2, 0, 0);
        set_ramp16();
        exp_v = '{-768, -256, 1280, 1792};
        run(1'b1, 1'b0);
        check_frame("ramp_gap", 4, 2);

        do_start(1, 2, 0, 0);
        pix = '{3 * 65536};
        exp_v.delete();
        run(1'b0, 1'b0);
        check_frame("fea_lt_pool", 1, 2);

        // Restart mid-frame: nothing from the old frame may leak out.
        do_start(4, 1, 0, 0);
        set_bypass16();
        feed(7, 1'b0);
        do_start(4, 2, 1, 0);
        chk("abort_stale", outq.size(), 0);
        set_ramp16();
        exp_v = '{0, 0, 1280, 1792};
        run(1'b0, 1'b0);
        check_frame("abort", 4, 2);

        do_start(4, 1, 0, 0);
        set_bypass16();
        feed(6, 1'b0);
        outq.delete();
        outc.delete();
        rst = 1'b1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("midrst_stale", outq.size(), 0);
        chk("midrst_done", done_cnt, 0);
        do_start(4, 2, 1, 0);
        set_ramp16();
        exp_v = '{0, 0, 1280, 1792};
        run(1'b0, 1'b0);
        check_frame("post_rst", 4, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
